hevc_dct8_mac_seq: RTL and testbench

Serial sequencer for the 8-point HEVC transform. It accepts one 8-sample vector, walks the 8x8 signed coefficient ROM (row, col → signed 8-bit) one coefficient per cycle, and accumulates on a single multiply-accumulate unit. Each of the 8 outputs is rounded, shifted and saturated, then streamed out on a valid/ready port. It sits between the transpose buffer and the next transform stage, and it owns the ROM address lines exclusively.

---
 rtl/hevc_dct8_mac_seq.sv | 145 ++++++++++++++
 tb/tb_hevc_dct8_mac_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hevc_dct8_mac_seq.sv
// Serial 8-point HEVC transform: one coefficient per cycle on a single MAC,
// with rounded, saturated outputs streamed on a valid/ready port.
module hevc_dct8_mac_seq #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*IN_W-1:0]     in_data,
  input  logic                  in_inv,
  output logic [2:0]            rom_row,
  output logic [2:0]            rom_col,
  input  logic [7:0]            rom_coeff,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [2:0]            out_idx,
  output logic                  out_last,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Valid-side outputs stay frozen while valid && !ready.

  localparam int PROD_W = IN_W + 8;
  localparam int ACC_W  = IN_W + 11;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [8*IN_W-1:0]        r_x;
  logic                     r_inv;
  logic [2:0]               r_n;
  logic [2:0]               r_k;
  logic signed [ACC_W-1:0]  r_acc;
  logic [OUT_W-1:0]         r_out_data;

  logic signed [7:0]        w_coeff;
  logic signed [IN_W-1:0]   w_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_shr;
  logic [OUT_W-1:0]         w_sat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    rom_row     = 3'd0;
    rom_col     = 3'd0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        // Inverse walks the transposed matrix: row=k, col=n.
        rom_row = r_inv ? r_k : r_n;
        rom_col = r_inv ? r_n : r_k;
        if (r_k == 3'd7) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = (r_n == 3'd7) ? S_IDLE : S_MAC;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_coeff   = rom_coeff;
  assign w_x       = r_x[32'(r_k) * IN_W +: IN_W];
  assign w_prod    = PROD_W'(w_coeff) * PROD_W'(w_x);
  assign w_acc_nxt = r_acc + ACC_W'(w_prod);
  assign w_sum     = SUM_W'(w_acc_nxt) + ROUND_C;
  assign w_shr     = w_sum >>> SHIFT;

  always_comb begin
    w_sat = w_shr[OUT_W-1:0];
    if (w_shr > SAT_MAX)      w_sat = SAT_MAX[OUT_W-1:0];
    else if (w_shr < SAT_MIN) w_sat = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_inv      <= 1'b0;
      r_n        <= 3'd0;
      r_k        <= 3'd0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x   <= in_data;
            r_inv <= in_inv;
            r_n   <= 3'd0;
            r_k   <= 3'd0;
            r_acc <= '0;
          end
        end
        S_MAC: begin
          // The final term is folded in combinationally so the result lands
          // in the same edge that leaves MAC; k wraps back to 0 here.
          r_acc <= w_acc_nxt;
          r_k   <= r_k + 3'd1;
          if (r_k == 3'd7) r_out_data <= w_sat;
        end
        S_OUT: begin
          if (out_ready) begin
            r_n   <= r_n + 3'd1;
            r_k   <= 3'd0;
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_idx   = r_n;
  assign out_last  = out_valid && (r_n == 3'd7);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hevc_dct8_mac_seq.sv
// Self-checking bench for hevc_dct8_mac_seq: drives vectors against a ROM
// model and checks outputs against an arithmetic reference of the transform.
module tb_hevc_dct8_mac_seq;

  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int SHIFT = 7;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [8*IN_W-1:0]    in_data;
  logic                 in_inv;
  logic [2:0]           rom_row;
  logic [2:0]           rom_col;
  logic [7:0]           rom_coeff;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic [2:0]           out_idx;
  logic                 out_last;
  logic [1:0]           dbg_state;

  int n_vec;
  int n_bad;

  int c_tab [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}
  };

  hevc_dct8_mac_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .rom_row   (rom_row),
    .rom_col   (rom_col),
    .rom_coeff (rom_coeff),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb rom_coeff = 8'(c_tab[rom_row][rom_col]);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference: y[n] = sum_k C*x, then floor((y + 2^(S-1)) / 2^S), then clamp.
  function automatic int model_y(bit inv, int xs[8], int n);
    longint s;
    longint lim_hi;
    longint lim_lo;
    s = 0;
    for (int k = 0; k < 8; k++)
      s += longint'(inv ? c_tab[k][n] : c_tab[n][k]) * longint'(xs[k]);
    s = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    lim_hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lim_lo = -(longint'(1) <<< (OUT_W - 1));
    if (s > lim_hi) s = lim_hi;
    if (s < lim_lo) s = lim_lo;
    return int'(s);
  endfunction

  // Driver + scoreboard for one vector. stall_idx<0 disables the fixed stall.
  task automatic drive_and_check(input bit inv, input int xs[8], input int stall_idx,
                                 input int stall_len, input bit rand_ready,
                                 input bit chk_timing);
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] held_d;
    logic [2:0]       held_i;
    int e, got, stall_cnt, waited, first_v;
    bit seen;
    for (int n = 0; n < 8; n++) exp_q.push_back(OUT_W'(model_y(inv, xs, n)));
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL accept_wait: in_ready=%0b required 1 within 200 cycles", in_ready);
      return;
    end
    for (int k = 0; k < 8; k++) in_data[k*IN_W +: IN_W] = IN_W'(xs[k]);
    in_inv   = inv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = {4{32'($urandom)}};
    in_inv    = 1'($urandom_range(0, 1));
    e         = 0;
    got       = 0;
    seen      = 1'b0;
    stall_cnt = 0;
    first_v   = -1;
    held_d    = '0;
    held_i    = '0;
    while (got < 8 && e < 3000) begin
      if (out_valid) begin
        if (first_v < 0) first_v = e;
        if (!seen) begin
          n_vec++;
          if (out_data !== exp_q[0]) begin
            n_bad++;
            $display("FAIL out_data idx%0d inv=%0b: got %0d required %0d", got, inv,
                     $signed(out_data), $signed(exp_q[0]));
          end
          n_vec++;
          if (out_idx !== 3'(got)) begin
            n_bad++;
            $display("FAIL out_idx: got %0d required %0d", out_idx, got);
          end
          n_vec++;
          if (out_last !== (got == 7)) begin
            n_bad++;
            $display("FAIL out_last idx%0d: got %0b required %0b", got, out_last, (got == 7));
          end
          seen      = 1'b1;
          held_d    = out_data;
          held_i    = out_idx;
          stall_cnt = 0;
        end else begin
          n_vec++;
          if (out_data !== held_d || out_idx !== held_i) begin
            n_bad++;
            $display("FAIL hold_stable: got data=%0h idx=%0d required data=%0h idx=%0d",
                     out_data, out_idx, held_d, held_i);
          end
        end
        if (got == stall_idx && stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
          n_vec++;
          if (rom_row !== 3'd0 || rom_col !== 3'd0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_idle: got row=%0d col=%0d in_ready=%0b required 0 0 0",
                     rom_row, rom_col, in_ready);
          end
          in_valid = 1'($urandom_range(0, 1));
          in_data  = {4{32'($urandom)}};
        end else if (rand_ready && $urandom_range(0, 2) == 0) begin
          out_ready = 1'b0;
          in_valid  = 1'b0;
        end else begin
          out_ready = 1'b1;
          in_valid  = 1'b0;
          got++;
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = 1'b0;
      end
      @(negedge clk);
      e++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_vec++;
    if (got < 8) begin
      n_bad++;
      $display("FAIL stream_timeout: got %0d samples required 8", got);
      return;
    end
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL return_idle: got in_ready=%0b out_valid=%0b required 1 0",
               in_ready, out_valid);
    end
    if (chk_timing) begin
      n_vec++;
      if (first_v != 8) begin
        n_bad++;
        $display("FAIL first_valid_time: got T0+%0d required T0+9", first_v + 1);
      end
      n_vec++;
      if (e != 72) begin
        n_bad++;
        $display("FAIL ready_return_time: got T0+%0d required T0+73", e + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    in_data   = {4{32'($urandom)}};
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_idx !== 3'd0 ||
        out_last !== 1'b0 || rom_row !== 3'd0 || rom_col !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%0b vld=%0b data=%0h idx=%0d last=%0b row=%0d col=%0d required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_data, out_idx, out_last, rom_row, rom_col);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL no_accept_in_reset: got in_ready=%0b out_valid=%0b required 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_inverse_dc();
    int xs[8] = '{64, 0, 0, 0, 0, 0, 0, 0};
    drive_and_check(1'b1, xs, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_forward_dc();
    int xs[8] = '{100, 100, 100, 100, 100, 100, 100, 100};
    drive_and_check(1'b0, xs, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_inverse_odd();
    int xs[8] = '{0, 100, 0, 0, 0, 0, 0, 0};
    drive_and_check(1'b1, xs, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    int xp[8] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    int xn[8] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    drive_and_check(1'b0, xp, -1, 0, 1'b0, 1'b0);
    drive_and_check(1'b0, xn, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    int xs[8];
    for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 65535)) - 32768;
    drive_and_check(1'($urandom_range(0, 1)), xs, 3, 5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int xs[8];
    int e;
    for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 65535)) - 32768;
    for (int k = 0; k < 8; k++) in_data[k*IN_W +: IN_W] = IN_W'(xs[k]);
    in_inv    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    e = 0;
    while (!(out_idx == 3'd2 && !out_valid) && e < 100) begin
      @(negedge clk);
      e++;
    end
    n_vec++;
    if (e >= 100) begin
      n_bad++;
      $display("FAIL reach_idx2: got idx=%0d required 2 within 100 cycles", out_idx);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0 ||
        rom_row !== 3'd0 || rom_col !== 3'd0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got vld=%0b rdy=%0b idx=%0d row=%0d col=%0d data=%0h required 0 1 0 0 0 0",
               out_valid, in_ready, out_idx, rom_row, rom_col, out_data);
    end
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 65535)) - 32768;
    drive_and_check(1'b1, xs, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int xs[8];
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 65535)) - 32768;
      drive_and_check(1'($urandom_range(0, 1)), xs, int'($urandom_range(0, 7)),
                      int'($urandom_range(1, 4)), 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int xs[8];
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) xs[k] = int'($urandom_range(0, 2000)) - 1000;
      drive_and_check(1'(i), xs, -1, 0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_inverse_dc();
    test_forward_dc();
    test_inverse_odd();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
